// File: rtl/fltpt_add_pipe.sv
// Three-stage IEEE-754-style adder/subtractor: S1 unpack/classify/swap/align,
// S2 add-subtract/normalise, S3 round-to-nearest-even/pack/flags.
module fltpt_add_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  localparam int W = 1 + EXP_W + MAN_W
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic         i_sub,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [W-1:0] o_result,
  output logic [3:0]   o_flags
);
  // Handshake: operands move in on i_valid && o_ready, results move out on
  // o_valid && i_ready; an unaccepted result freezes the whole pipe (o_ready=0).
  localparam int MW = MAN_W + 4;  // hidden + fraction + guard/round/sticky
  localparam logic [EXP_W-1:0] EMAX = '1;
  localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  logic w_stall, w_en;
  assign w_stall = o_valid && !i_ready;
  assign w_en    = !w_stall;
  assign o_ready = w_en;

  // ---------------- S1: unpack, classify, swap, align ----------------
  logic               w_sa, w_sb;
  logic [EXP_W-1:0]   w_ea, w_eb;
  logic [MAN_W-1:0]   w_fa, w_fb;
  logic               w_a_nan, w_b_nan, w_a_snan, w_b_snan, w_a_inf, w_b_inf;
  logic               w_swap, w_big_s, w_hid_big, w_hid_sml;
  logic [EXP_W-1:0]   w_e_big, w_e_sml, w_diff;
  logic [MAN_W-1:0]   w_f_big, w_f_sml;
  logic [MW-1:0]      w_ext_sml, w_mask, w_aligned;
  logic               w_spec, w_spec_nv;
  logic [W-1:0]       w_spec_res;

  assign w_sa = i_a[W-1];
  assign w_ea = i_a[W-2:MAN_W];
  assign w_fa = i_a[MAN_W-1:0];
  assign w_sb = i_b[W-1] ^ i_sub;
  assign w_eb = i_b[W-2:MAN_W];
  assign w_fb = i_b[MAN_W-1:0];

  assign w_a_nan  = (w_ea == EMAX) && (w_fa != '0);
  assign w_b_nan  = (w_eb == EMAX) && (w_fb != '0);
  assign w_a_snan = w_a_nan && !w_fa[MAN_W-1];
  assign w_b_snan = w_b_nan && !w_fb[MAN_W-1];
  assign w_a_inf  = (w_ea == EMAX) && (w_fa == '0);
  assign w_b_inf  = (w_eb == EMAX) && (w_fb == '0);

  // Larger magnitude goes to the "big" lane so subtraction never goes negative.
  assign w_swap    = {w_eb, w_fb} > {w_ea, w_fa};
  assign w_big_s   = w_swap ? w_sb : w_sa;
  assign w_hid_big = w_swap ? (w_eb != '0) : (w_ea != '0);
  assign w_hid_sml = w_swap ? (w_ea != '0) : (w_eb != '0);
  assign w_e_big   = w_swap ? ((w_eb == '0) ? EXP_W'(1) : w_eb) : ((w_ea == '0) ? EXP_W'(1) : w_ea);
  assign w_e_sml   = w_swap ? ((w_ea == '0) ? EXP_W'(1) : w_ea) : ((w_eb == '0) ? EXP_W'(1) : w_eb);
  assign w_f_big   = w_swap ? w_fb : w_fa;
  assign w_f_sml   = w_swap ? w_fa : w_fb;
  assign w_diff    = w_e_big - w_e_sml;
  assign w_ext_sml = {w_hid_sml, w_f_sml, 3'b000};
  assign w_mask    = (MW'(1) << w_diff) - MW'(1);

  always_comb begin
    w_aligned = w_ext_sml >> w_diff;
    if ({{(32-EXP_W){1'b0}}, w_diff} >= 32'(MAN_W + 3)) begin
      w_aligned = {{(MW-1){1'b0}}, |w_ext_sml};
    end else begin
      w_aligned[0] = w_aligned[0] | (|(w_ext_sml & w_mask));
    end
  end

  always_comb begin
    w_spec     = 1'b0;
    w_spec_nv  = 1'b0;
    w_spec_res = QNAN;
    if (w_a_nan || w_b_nan) begin
      w_spec    = 1'b1;
      w_spec_nv = w_a_snan || w_b_snan;
    end else if (w_a_inf && w_b_inf && (w_sa != w_sb)) begin
      w_spec    = 1'b1;
      w_spec_nv = 1'b1;
    end else if (w_a_inf) begin
      w_spec     = 1'b1;
      w_spec_res = {w_sa, EMAX, {MAN_W{1'b0}}};
    end else if (w_b_inf) begin
      w_spec     = 1'b1;
      w_spec_res = {w_sb, EMAX, {MAN_W{1'b0}}};
    end
  end

  logic             r1_valid, r1_spec, r1_spec_nv, r1_sign, r1_sub, r1_zsign;
  logic [W-1:0]     r1_spec_res;
  logic [EXP_W-1:0] r1_exp;
  logic [MW-1:0]    r1_mbig, r1_msml;

  // ---------------- S2: add/subtract, normalise ----------------
  logic [MW:0]      w_sum;
  logic [MW-1:0]    w_man;
  logic [EXP_W:0]   w_exp;
  int               w_lz, w_sh;
  logic             w_found;

  assign w_sum = r1_sub ? ({1'b0, r1_mbig} - {1'b0, r1_msml})
                        : ({1'b0, r1_mbig} + {1'b0, r1_msml});

  always_comb begin
    w_lz    = 0;
    w_found = 1'b0;
    for (int i = MW - 1; i >= 0; i--) begin
      if (!w_found) begin
        if (w_sum[i]) w_found = 1'b1;
        else          w_lz    = w_lz + 1;
      end
    end
    // Left shift stops at exponent 1 so tiny results fall out as subnormals.
    w_sh  = (w_lz < int'(r1_exp) - 1) ? w_lz : int'(r1_exp) - 1;
    w_man = w_sum[MW-1:0] << w_sh;
    w_exp = {1'b0, r1_exp} - (EXP_W+1)'(w_sh);
    if (w_sum[MW]) begin
      w_man = w_sum[MW:1] | {{(MW-1){1'b0}}, w_sum[0]};
      w_exp = {1'b0, r1_exp} + (EXP_W+1)'(1);
    end
  end

  logic             r2_valid, r2_spec, r2_spec_nv, r2_sign, r2_zsign;
  logic [W-1:0]     r2_spec_res;
  logic [EXP_W:0]   r2_exp;
  logic [MW-1:0]    r2_man;

  // ---------------- S3: round, pack, flags ----------------
  logic             w_inexact, w_rup, w_hid;
  logic [MAN_W+1:0] w_rnd;
  logic [MAN_W-1:0] w_frac;
  logic [EXP_W:0]   w_exp_r;
  logic [W-1:0]     w_res;
  logic [3:0]       w_flags;

  assign w_inexact = |r2_man[2:0];
  assign w_rup     = r2_man[2] && (r2_man[1] || r2_man[0] || r2_man[3]);
  assign w_rnd     = {1'b0, r2_man[MW-1:3]} + (MAN_W+2)'(w_rup);

  always_comb begin
    w_exp_r = r2_exp;
    w_frac  = w_rnd[MAN_W-1:0];
    w_hid   = w_rnd[MAN_W];
    if (w_rnd[MAN_W+1]) begin
      w_exp_r = r2_exp + (EXP_W+1)'(1);
      w_frac  = w_rnd[MAN_W:1];
      w_hid   = 1'b1;
    end
    w_res   = {r2_sign, (w_hid ? w_exp_r[EXP_W-1:0] : {EXP_W{1'b0}}), w_frac};
    w_flags = {2'b00, w_inexact && !w_hid, w_inexact};
    if (r2_spec) begin
      w_res   = r2_spec_res;
      w_flags = {r2_spec_nv, 3'b000};
    end else if (r2_man == '0) begin
      w_res   = {r2_zsign, {(W-1){1'b0}}};
      w_flags = 4'b0000;
    end else if (w_hid && (w_exp_r >= {1'b0, EMAX})) begin
      w_res   = {r2_sign, EMAX, {MAN_W{1'b0}}};
      w_flags = 4'b0101;
    end
  end

  logic         r3_valid;
  logic [W-1:0] r3_result;
  logic [3:0]   r3_flags;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r1_valid  <= 1'b0;
      r2_valid  <= 1'b0;
      r3_valid  <= 1'b0;
      r3_result <= '0;
      r3_flags  <= '0;
    end else if (w_en) begin
      r1_valid  <= i_valid;
      r2_valid  <= r1_valid;
      r3_valid  <= r2_valid;
      r3_result <= w_res;
      r3_flags  <= w_flags;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_en) begin
      r1_spec     <= w_spec;
      r1_spec_nv  <= w_spec_nv;
      r1_spec_res <= w_spec_res;
      r1_sign     <= w_big_s;
      r1_sub      <= w_sa ^ w_sb;
      r1_zsign    <= w_sa & w_sb;
      r1_exp      <= w_e_big;
      r1_mbig     <= {w_hid_big, w_f_big, 3'b000};
      r1_msml     <= w_aligned;
      r2_spec     <= r1_spec;
      r2_spec_nv  <= r1_spec_nv;
      r2_spec_res <= r1_spec_res;
      r2_sign     <= r1_sign;
      r2_zsign    <= r1_zsign;
      r2_exp      <= w_exp;
      r2_man      <= w_man;
    end
  end

  assign o_valid  = r3_valid;
  assign o_result = r3_result;
  assign o_flags  = r3_flags;
endmodule

// File: tb/tb_fltpt_add_pipe.sv
// Bench for fltpt_add_pipe: directed single-precision vectors, a 4-cycle
// output stall mid-stream, and reset with operations in flight.
module tb_fltpt_add_pipe;
  localparam int EXP_W = 8;
  localparam int MAN_W = 23;
  localparam int W     = 1 + EXP_W + MAN_W;

  logic         i_clk = 1'b0;
  logic         i_rst;
  logic         i_valid;
  logic         o_ready;
  logic [W-1:0] i_a, i_b;
  logic         i_sub;
  logic         o_valid;
  logic         i_ready;
  logic [W-1:0] o_result;
  logic [3:0]   o_flags;

  fltpt_add_pipe #(.EXP_W(EXP_W), .MAN_W(MAN_W)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_a(i_a), .i_b(i_b), .i_sub(i_sub), .o_valid(o_valid),
    .i_ready(i_ready), .o_result(o_result), .o_flags(o_flags)
  );

  // ---------------- clock / reset ----------------
  always #5 i_clk = ~i_clk;

  int cnt = 0;
  always @(posedge i_clk) cnt <= cnt + 1;

  // ---------------- scoreboard state ----------------
  int             total = 0;
  int             bad   = 0;
  logic [W+3:0]   exp_q[$];
  int             cyc_q[$];
  bit             lat_chk = 1'b1;
  int             stall_seen = 0;
  logic           prev_stall = 1'b0;
  logic [W-1:0]   prev_res;
  logic [3:0]     prev_flg;
  logic [W+3:0]   e_item;
  int             c_item;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge i_clk) begin
    if (i_rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("hold_valid", 64'(o_valid), 64'd1);
        chk("hold_result", 64'(o_result), 64'(prev_res));
        chk("hold_flags", 64'(o_flags), 64'(prev_flg));
      end
      if (o_valid) chk("ready_vs_stall", 64'(o_ready), 64'(i_ready));
      else         chk("ready_idle", 64'(o_ready), 64'd1);
      if (o_valid && !i_ready) stall_seen++;
      if (o_valid && i_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_output actual=%0h required=none", o_result);
        end else begin
          e_item = exp_q.pop_front();
          c_item = cyc_q.pop_front();
          chk("result", 64'(o_result), 64'(e_item[W+3:4]));
          chk("flags", 64'(o_flags), 64'(e_item[3:0]));
          if (lat_chk) chk("latency", 64'(cnt - c_item), 64'd3);
        end
      end
      prev_stall = o_valid && !i_ready;
      prev_res   = o_result;
      prev_flg   = o_flags;
    end
  end

  // ---------------- driver tasks ----------------
  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                      input logic [W-1:0] er, input logic [3:0] ef);
    bit acc;
    acc     = 1'b0;
    i_valid = 1'b1;
    i_a     = a;
    i_b     = b;
    i_sub   = sub;
    for (int n = 0; n < 50 && !acc; n++) begin
      @(negedge i_clk);
      if (o_ready) begin
        exp_q.push_back({er, ef});
        cyc_q.push_back(cnt);
        acc = 1'b1;
      end
      @(posedge i_clk);
      #1;
    end
    if (!acc) begin
      total++;
      bad++;
      $display("FAIL accept_timeout actual=o_ready_low required=accept");
    end
    i_valid = 1'b0;
  endtask

  task automatic drain();
    for (int n = 0; n < 100 && exp_q.size() != 0; n++) @(posedge i_clk);
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout actual=%0d required=0", exp_q.size());
    end
    @(posedge i_clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    i_rst = 1'b1; i_valid = 1'b0; i_a = '0; i_b = '0; i_sub = 1'b0; i_ready = 1'b0;
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    chk("rst_valid", 64'(o_valid), 64'd0);
    chk("rst_result", 64'(o_result), 64'd0);
    chk("rst_flags", 64'(o_flags), 64'd0);
    chk("rst_ready", 64'(o_ready), 64'd1);
    @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    i_ready = 1'b1;

    // flags = {NV, OF, UF, NX}
    send(32'h3F000000, 32'h40900000, 1'b0, 32'h40A00000, 4'b0000); // 0.5 + 4.5
    send(32'h00000001, 32'h00000002, 1'b0, 32'h00000003, 4'b0000); // subnormals
    send(32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 4'b0000); // 1 - 1 = +0
    send(32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000, 4'b1000); // inf - inf
    send(32'h7FC00000, 32'h3F800000, 1'b0, 32'h7FC00000, 4'b0000); // qNaN propagate
    send(32'h7F800000, 32'h3F800000, 1'b0, 32'h7F800000, 4'b0000); // inf + 1
    send(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 4'b0101); // overflow
    send(32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 4'b0001); // tie to even, down
    send(32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 4'b0001); // tie to even, up
    send(32'h3F800000, 32'h33C00000, 1'b0, 32'h3F800001, 4'b0001); // above half
    send(32'h3FFFFFFF, 32'h33800000, 1'b0, 32'h40000000, 4'b0001); // round carry
    send(32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 4'b0000); // -0 + -0
    send(32'h00000000, 32'h80000000, 1'b0, 32'h00000000, 4'b0000); // +0 + -0
    send(32'h7F800001, 32'h3F800000, 1'b0, 32'h7FC00000, 4'b1000); // sNaN
    send(32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 4'b1000); // inf - inf via i_sub
    send(32'h3F800000, 32'h00000001, 1'b0, 32'h3F800000, 4'b0001); // far shift, sticky only
    send(32'h3F800000, 32'h3F7FFFFF, 1'b1, 32'h33800000, 4'b0000); // cancellation
    send(32'h00400000, 32'h00400000, 1'b0, 32'h00800000, 4'b0000); // subnormal -> normal
    send(32'h4B800000, 32'h40400000, 1'b0, 32'h4B800002, 4'b0001); // 2^24 + 3
    drain();

    // output stall of 4 cycles in a 5-deep stream
    lat_chk = 1'b0;
    stall_seen = 0;
    fork
      begin
        send(32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 4'b0000);
        send(32'h3F800000, 32'h3F000000, 1'b1, 32'h3F000000, 4'b0000);
        send(32'hBF800000, 32'h3F000000, 1'b0, 32'hBF000000, 4'b0000);
        send(32'h3F800000, 32'hC0000000, 1'b0, 32'hBF800000, 4'b0000);
        send(32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 4'b0001);
      end
      begin
        repeat (3) @(posedge i_clk);
        #1;
        i_ready = 1'b0;
        repeat (4) @(posedge i_clk);
        #1;
        i_ready = 1'b1;
      end
    join
    drain();
    chk("stall_cycles", 64'(stall_seen), 64'd4);
    lat_chk = 1'b1;

    // reset with three operations in flight
    send(32'h40000000, 32'h40000000, 1'b0, 32'h40800000, 4'b0000);
    send(32'h40400000, 32'h3F800000, 1'b0, 32'h40800000, 4'b0000);
    send(32'h40800000, 32'h40800000, 1'b0, 32'h41000000, 4'b0000);
    i_rst = 1'b1;
    #1;
    chk("midrst_valid", 64'(o_valid), 64'd0);
    chk("midrst_result", 64'(o_result), 64'd0);
    chk("midrst_flags", 64'(o_flags), 64'd0);
    chk("midrst_ready", 64'(o_ready), 64'd1);
    exp_q.delete();
    cyc_q.delete();
    @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    repeat (6) @(posedge i_clk);
    #1;
    send(32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 4'b0000);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule
